// File: rtl/cpu_types_pkg.sv
// Shared processor types: RAM handshake states, arbiter FSM states and
// counter widths used by the memory arbiter.
package cpu_types_pkg;

  localparam int WORD_W   = 32;
  localparam int STARVE_W = 3;
  localparam int TMO_W    = 8;

  typedef logic [WORD_W-1:0] word_t;

  // RAM model handshake state, as seen on ramstate.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter ownership of the RAM port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arbstate_t;

  // Saturating increment for the fetch-starvation counter.
  function automatic logic [STARVE_W-1:0] starve_bump(
    input logic [STARVE_W-1:0] cur,
    input logic [STARVE_W-1:0] max
  );
    if (cur >= max) begin
      return cur;
    end else begin
      return cur + STARVE_W'(1);
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle around the memory arbiter: the ma modport is the arbiter
// itself, dp is the datapath/cache side, ram is the RAM model side.
interface mem_arbiter_if (input logic CLK);
  import cpu_types_pkg::*;

  logic      RST;
  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      fault;

  modport ma (
    input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, fault
  );

  modport dp (
    input  CLK, iload, iwait, dload, dwait, fault,
    output RST, iREN, iaddr, dREN, dWEN, daddr, dstore
  );

  modport ram (
    input  CLK, ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory.
// Data has priority; fetch is forced through after STARVE_MAX consecutive
// data grants while it waits. A watchdog aborts a grant that never sees
// ACCESS within TIMEOUT cycles. Requester inputs are steered to the RAM
// combinationally, so the wait/load outputs respond in the same cycle the
// RAM reports ACCESS or ERROR.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic      CLK,
  input  logic      RST,
  // instruction fetch side
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  // data memory side
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  // RAM side
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      fault
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [TMO_W-1:0]    TMO_LIM    = TMO_W'(TIMEOUT);

  arbstate_t           state_q,  state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [TMO_W-1:0]    tmo_q,    tmo_d;

  logic dreq;
  logic starve_full;
  logic tmo_hit;
  logic ram_done;
  logic ram_err;

  assign dreq        = dREN | dWEN;
  assign starve_full = (starve_q == STARVE_LIM);
  assign tmo_hit     = (tmo_q == TMO_LIM);
  assign ram_done    = (ramstate == ACCESS);
  assign ram_err     = (ramstate == ERROR);

  // State and counter registers with synchronous reset; a reset mid-grant
  // simply drops the in-flight access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state, counter update and RAM/requester output steering.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = iREN;
    dwait    = dreq;
    fault    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Watchdog starts from zero on every grant.
        tmo_d = '0;
        if (!iREN) begin
          starve_d = '0;
        end else begin
          starve_d = starve_q;
        end
        // Data wins unless fetch has already been passed over too often.
        if (dreq && !(iREN && starve_full)) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end else begin
          state_d = IDLE;
        end
      end

      IGRANT: begin
        if (!iREN) begin
          // Fetch withdrew: release the port quietly.
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_done) begin
            // ACCESS takes precedence over a coincident timeout.
            iwait    = 1'b0;
            iload    = ramload;
            starve_d = '0;
            state_d  = IDLE;
          end else if (ram_err || tmo_hit) begin
            iwait    = 1'b0;
            fault    = 1'b1;
            starve_d = '0;
            state_d  = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end

      DGRANT: begin
        if (!dreq) begin
          // Data withdrew: release the port quietly.
          state_d = IDLE;
        end else begin
          // A write wins over a simultaneous read request.
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ram_done) begin
            dwait = 1'b0;
            if (dWEN) begin
              dload = '0;
            end else begin
              dload = ramload;
            end
            if (iREN) begin
              starve_d = starve_bump(starve_q, STARVE_LIM);
            end else begin
              starve_d = starve_q;
            end
            state_d = IDLE;
          end else if (ram_err || tmo_hit) begin
            dwait = 1'b0;
            fault = 1'b1;
            if (iREN) begin
              starve_d = starve_bump(starve_q, STARVE_LIM);
            end else begin
              starve_d = starve_q;
            end
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end

      default: begin
        state_d  = IDLE;
        starve_d = '0;
        tmo_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions into
// a scoreboard queue; a negedge monitor pops and compares whenever a
// requester's wait drops while its request is up.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus (.CLK(clk));

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(255)) dut (
    .CLK      (clk),
    .RST      (bus.RST),
    .iREN     (bus.iREN),
    .iaddr    (bus.iaddr),
    .iload    (bus.iload),
    .iwait    (bus.iwait),
    .dREN     (bus.dREN),
    .dWEN     (bus.dWEN),
    .daddr    (bus.daddr),
    .dstore   (bus.dstore),
    .dload    (bus.dload),
    .dwait    (bus.dwait),
    .ramREN   (bus.ramREN),
    .ramWEN   (bus.ramWEN),
    .ramaddr  (bus.ramaddr),
    .ramstore (bus.ramstore),
    .ramload  (bus.ramload),
    .ramstate (bus.ramstate),
    .fault    (bus.fault)
  );

  typedef struct {
    int    tag;
    bit    is_data;
    word_t load;
    bit    flt;
    word_t addr;
    bit    wen;
    word_t store;
    int    cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_tag    = 0;
  int   cyc      = 0;

  // RAM model knobs: mode 0 = ACCESS after ram_lat busy cycles,
  // 1 = ERROR after ram_lat busy cycles, 2 = BUSY forever.
  int    ram_lat  = 0;
  int    ram_mode = 0;
  int    ram_cnt  = 0;
  word_t ram_data = '0;

  // Cycle counter used for latency expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // RAM responder, updated shortly after each edge once strobes settle.
  always @(posedge clk) begin
    #2;
    bus.ramload = ram_data;
    if (bus.ramREN || bus.ramWEN) begin
      if (ram_mode == 2) bus.ramstate = BUSY;
      else if (ram_cnt >= ram_lat) bus.ramstate = (ram_mode == 1) ? ERROR : ACCESS;
      else bus.ramstate = BUSY;
      ram_cnt++;
    end else begin
      bus.ramstate = FREE;
      ram_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, want, cyc);
  endtask

  task automatic push(input bit d, input word_t load, input bit f, input word_t addr,
                      input bit wen, input word_t store, input int c);
    exp_t e;
    e.tag = n_tag; e.is_data = d; e.load = load; e.flt = f; e.addr = addr;
    e.wen = wen; e.store = store; e.cyc = c;
    sb_q.push_back(e);
    n_tag++;
  endtask

  // Monitor: compare each completion/abort against the scoreboard head.
  bit   m_ci, m_cd;
  exp_t m_e;
  always @(negedge clk) begin
    if (bus.RST !== 1'b1) begin
      m_ci = bus.iREN && !bus.iwait;
      m_cd = (bus.dREN || bus.dWEN) && !bus.dwait;
      if (m_ci || m_cd) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_cmpl: got completion (data=%0d) at cycle %0d, required none", m_cd, cyc);
        end else begin
          m_e = sb_q.pop_front();
          check($sformatf("t%0d_owner", m_e.tag), {31'd0, m_cd}, {31'd0, m_e.is_data});
          check($sformatf("t%0d_load", m_e.tag), m_cd ? bus.dload : bus.iload, m_e.load);
          check($sformatf("t%0d_otherload", m_e.tag), m_cd ? bus.iload : bus.dload, 32'd0);
          check($sformatf("t%0d_fault", m_e.tag), {31'd0, bus.fault}, {31'd0, m_e.flt});
          check($sformatf("t%0d_addr", m_e.tag), bus.ramaddr, m_e.addr);
          check($sformatf("t%0d_wen", m_e.tag), {31'd0, bus.ramWEN}, {31'd0, m_e.wen});
          check($sformatf("t%0d_store", m_e.tag), bus.ramstore, m_e.store);
          check($sformatf("t%0d_cyc", m_e.tag), cyc, m_e.cyc);
        end
      end else if (bus.fault) begin
        n_checks++;
        $display("FAIL stray_fault: got fault=1 at cycle %0d, required 0", cyc);
      end
    end
  end

  // Wait (bounded) for the given side to complete, then step to the next cycle.
  task automatic wait_cmpl(input bit data_side, input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      if (data_side) done = (bus.dREN || bus.dWEN) && !bus.dwait;
      else           done = bus.iREN && !bus.iwait;
      n++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL wait_cmpl: got no completion after %0d cycles, required one (data=%0d)", budget, data_side);
    end
    @(posedge clk); #1;
  endtask

  task automatic next_cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int c0;

  initial begin
    bus.RST = 1'b1; bus.iREN = 1'b1; bus.iaddr = 32'h0000_0040;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
    ram_lat = 2; ram_mode = 0; ram_data = 32'h8C22_0004;

    // Reset held with a pending fetch: nothing reaches the RAM.
    @(posedge clk);
    @(negedge clk);
    check("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check("rst_iwait", {31'd0, bus.iwait}, 32'd1);
    check("rst_dwait", {31'd0, bus.dwait}, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    @(posedge clk); #1;
    bus.RST = 1'b0;

    // Single fetch: BUSY 2 cycles then ACCESS; completes at cycle 3.
    c0 = cyc;
    push(1'b0, 32'h8C22_0004, 1'b0, 32'h0000_0040, 1'b0, 32'd0, c0 + 3);
    @(negedge clk);
    check("f_c0_iwait", {31'd0, bus.iwait}, 32'd1);
    check("f_c0_ramREN", {31'd0, bus.ramREN}, 32'd0);
    @(negedge clk);
    check("f_c1_iwait", {31'd0, bus.iwait}, 32'd1);
    check("f_c1_ramREN", {31'd0, bus.ramREN}, 32'd1);
    check("f_c1_ramaddr", bus.ramaddr, 32'h0000_0040);
    @(negedge clk);
    check("f_c2_iwait", {31'd0, bus.iwait}, 32'd1);
    wait_cmpl(1'b0, 10);
    bus.iREN = 1'b0;
    next_cycle(1);

    // Simultaneous fetch and write: write first, fetch after one IDLE cycle.
    ram_lat = 1; ram_data = 32'h1111_2222;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0044;
    bus.dWEN = 1'b1; bus.daddr = 32'h0000_0100; bus.dstore = 32'hDEAD_BEEF;
    c0 = cyc;
    push(1'b1, 32'd0, 1'b0, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, c0 + 2);
    push(1'b0, 32'h1111_2222, 1'b0, 32'h0000_0044, 1'b0, 32'd0, c0 + 5);
    wait_cmpl(1'b1, 10);
    bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    wait_cmpl(1'b0, 10);
    bus.iREN = 1'b0;
    next_cycle(1);

    // Starvation: four back-to-back data reads, then fetch is forced in.
    ram_lat = 0; ram_data = 32'h0000_5A5A;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0048;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0300;
    c0 = cyc;
    for (int k = 0; k < 4; k++)
      push(1'b1, 32'h0000_5A5A, 1'b0, 32'h0000_0300, 1'b0, 32'd0, c0 + 1 + 2 * k);
    push(1'b0, 32'h0000_5A5A, 1'b0, 32'h0000_0048, 1'b0, 32'd0, c0 + 9);
    wait_cmpl(1'b0, 20);
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    next_cycle(1);

    // RAM ERROR during a data read: abort with zero load and a fault pulse.
    ram_mode = 1; ram_lat = 1;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0204;
    c0 = cyc;
    push(1'b1, 32'd0, 1'b1, 32'h0000_0204, 1'b0, 32'd0, c0 + 2);
    wait_cmpl(1'b1, 10);
    bus.dREN = 1'b0; ram_mode = 0;
    next_cycle(1);

    // RAM never answers: watchdog aborts when tmo reaches 255.
    ram_mode = 2;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_004C;
    c0 = cyc;
    push(1'b0, 32'd0, 1'b1, 32'h0000_004C, 1'b0, 32'd0, c0 + 256);
    wait_cmpl(1'b0, 300);
    bus.iREN = 1'b0; ram_mode = 0;
    next_cycle(1);

    // ACCESS in the same cycle tmo reaches 255: completes without fault.
    ram_lat = 255; ram_data = 32'hCAFE_F00D;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0050;
    c0 = cyc;
    push(1'b0, 32'hCAFE_F00D, 1'b0, 32'h0000_0050, 1'b0, 32'd0, c0 + 256);
    wait_cmpl(1'b0, 300);
    bus.iREN = 1'b0;
    next_cycle(1);

    // Data drops its request while granted: strobes fall, no fault.
    ram_mode = 2;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0208;
    next_cycle(2);
    bus.dREN = 1'b0;
    @(negedge clk);
    check("drop_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check("drop_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    check("drop_ramaddr", bus.ramaddr, 32'd0);
    check("drop_fault", {31'd0, bus.fault}, 32'd0);
    @(posedge clk); #1;
    // Arbiter must now be IDLE: a new fetch is granted next cycle.
    ram_mode = 0; ram_lat = 0; ram_data = 32'h0BAD_F00D;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0054;
    push(1'b0, 32'h0BAD_F00D, 1'b0, 32'h0000_0054, 1'b0, 32'd0, cyc + 1);
    wait_cmpl(1'b0, 10);
    bus.iREN = 1'b0;
    next_cycle(1);

    // Reset while a fetch is granted: next cycle is IDLE, no fault.
    ram_mode = 2;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0058;
    next_cycle(2);
    bus.RST = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstg_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check("rstg_ramaddr", bus.ramaddr, 32'd0);
    check("rstg_iwait", {31'd0, bus.iwait}, 32'd1);
    check("rstg_fault", {31'd0, bus.fault}, 32'd0);
    @(posedge clk); #1;
    bus.RST = 1'b0;
    ram_mode = 0; ram_lat = 0; ram_data = 32'h600D_600D;
    push(1'b0, 32'h600D_600D, 1'b0, 32'h0000_0058, 1'b0, 32'd0, cyc + 1);
    wait_cmpl(1'b0, 10);
    bus.iREN = 1'b0;
    next_cycle(3);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of test, required finish");
    $fatal(1, "timeout");
  end

endmodule
